irq_stim_port: RTL



---
 rtl/irq_stim_port_if.sv | 25 ++
 rtl/irq_stim_port.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_stim_port_if.sv
// Bus bundle for irq_stim_port: CPU register access, address snoop and
// the interrupt line / pending outputs.
interface irq_stim_port_if #(
  parameter int NUM_CH = 3
);
  logic              ready;
  logic              cs;
  logic [2:0]        addr;
  logic              write;
  logic [7:0]        data_i;
  logic [19:0]       bus_addr;
  logic [7:0]        data_o;
  logic [NUM_CH-1:0] lines;
  logic [NUM_CH-1:0] pending;

  modport master (
    output ready, cs, addr, write, data_i, bus_addr,
    input  data_o, lines, pending
  );

  modport slave (
    input  ready, cs, addr, write, data_i, bus_addr,
    output data_o, lines, pending
  );
endinterface

// File: rtl/irq_stim_port.sv
// Interrupt stimulus generator: NUM_CH lines set by direct register writes or
// by per-channel delayed triggers fired when the CPU reads a snoop address.
module irq_stim_port #(
  parameter int          NUM_CH     = 3,
  parameter int          DELAY_W    = 8,
  parameter int          PULSE_LEN  = 4,
  parameter logic [19:0] TRIG_RESET = 20'h000FE
) (
  input logic           clk,
  input logic           reset,
  irq_stim_port_if.slave bus
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN - 1);

  localparam logic [2:0] REG_LINE   = 3'd0;
  localparam logic [2:0] REG_ARM    = 3'd1;
  localparam logic [2:0] REG_SEL    = 3'd2;
  localparam logic [2:0] REG_DELAY  = 3'd3;
  localparam logic [2:0] REG_MODE   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_TLO    = 3'd6;
  localparam logic [2:0] REG_THI    = 3'd7;

  // Architectural state
  logic [NUM_CH-1:0]  lines_r, pending_r, arm_r, pulse_r, oneshot_r;
  logic [DELAY_W-1:0] delay_r [NUM_CH];
  logic [DELAY_W-1:0] cnt_r   [NUM_CH];
  logic [PW-1:0]      pcnt_r  [NUM_CH];
  logic [2:0]         ch_sel_r;
  logic [15:0]        trig_r;     // upper snoop nibble is always zero
  logic [7:0]         data_o_r;

  // Next-state values
  logic [NUM_CH-1:0]  lines_n, pending_n, arm_n, pulse_n, oneshot_n;
  logic [DELAY_W-1:0] delay_n [NUM_CH];
  logic [DELAY_W-1:0] cnt_n   [NUM_CH];
  logic [PW-1:0]      pcnt_n  [NUM_CH];
  logic [2:0]         ch_sel_n;
  logic [15:0]        trig_n;
  logic [7:0]         data_o_n;

  // Decoded strobes
  logic              wr_s, rd_s, trig_s;
  logic              line_wr_s, arm_wr_s, sel_wr_s, delay_wr_s, mode_wr_s, tlo_wr_s, thi_wr_s;
  logic [NUM_CH-1:0] fire_s;
  logic [7:0]        sel_delay_s, sel_mode_s, rdata_s;

  assign wr_s       = bus.cs & bus.write & bus.ready;
  assign rd_s       = bus.cs & ~bus.write;
  assign trig_s     = bus.ready & ~bus.write & (bus.bus_addr == {4'h0, trig_r}) & (trig_r != 16'h0000);
  assign line_wr_s  = wr_s & (bus.addr == REG_LINE);
  assign arm_wr_s   = wr_s & (bus.addr == REG_ARM);
  assign sel_wr_s   = wr_s & (bus.addr == REG_SEL);
  assign delay_wr_s = wr_s & (bus.addr == REG_DELAY);
  assign mode_wr_s  = wr_s & (bus.addr == REG_MODE);
  assign tlo_wr_s   = wr_s & (bus.addr == REG_TLO);
  assign thi_wr_s   = wr_s & (bus.addr == REG_THI);

  assign bus.data_o  = data_o_r;
  assign bus.lines   = lines_r;
  assign bus.pending = pending_r;

  // A channel expires when its countdown has reached zero while pending
  always_comb begin
    fire_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fire_s[i] = pending_r[i] & (cnt_r[i] == '0);
    end
  end

  // Per-channel countdown, line, pulse timer, arm and config next state
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      // Trigger (re)loads the countdown; it may coincide with expiry
      if (trig_s && arm_r[i]) begin
        cnt_n[i]     = delay_r[i];
        pending_n[i] = 1'b1;
      end else if (fire_s[i]) begin
        cnt_n[i]     = cnt_r[i];
        pending_n[i] = 1'b0;
      end else if (pending_r[i]) begin
        cnt_n[i]     = cnt_r[i] - DELAY_W'(1);
        pending_n[i] = 1'b1;
      end else begin
        cnt_n[i]     = cnt_r[i];
        pending_n[i] = 1'b0;
      end

      // Line priority: direct write, then expiry, then pulse auto-clear
      if (line_wr_s) begin
        lines_n[i] = bus.data_i[i];
      end else if (fire_s[i]) begin
        lines_n[i] = 1'b1;
      end else if (pulse_r[i] && lines_r[i] && (pcnt_r[i] == '0)) begin
        lines_n[i] = 1'b0;
      end else begin
        lines_n[i] = lines_r[i];
      end

      // Pulse timer restarts whenever the line is driven high
      if ((line_wr_s && bus.data_i[i]) || (!line_wr_s && fire_s[i])) begin
        pcnt_n[i] = PULSE_LOAD;
      end else if (pcnt_r[i] != '0) begin
        pcnt_n[i] = pcnt_r[i] - PW'(1);
      end else begin
        pcnt_n[i] = pcnt_r[i];
      end

      // A CPU write to ARM wins over the one-shot self-disarm
      if (arm_wr_s) begin
        arm_n[i] = bus.data_i[i];
      end else if (fire_s[i] && oneshot_r[i]) begin
        arm_n[i] = 1'b0;
      end else begin
        arm_n[i] = arm_r[i];
      end

      if (delay_wr_s && (ch_sel_r == 3'(i))) begin
        delay_n[i] = bus.data_i[DELAY_W-1:0];
      end else begin
        delay_n[i] = delay_r[i];
      end

      if (mode_wr_s && (ch_sel_r == 3'(i))) begin
        pulse_n[i]   = bus.data_i[0];
        oneshot_n[i] = bus.data_i[1];
      end else begin
        pulse_n[i]   = pulse_r[i];
        oneshot_n[i] = oneshot_r[i];
      end
    end
  end

  // Global registers: channel select and snoop address
  always_comb begin
    ch_sel_n = sel_wr_s ? bus.data_i[2:0] : ch_sel_r;
    trig_n   = trig_r;
    if (tlo_wr_s) begin
      trig_n[7:0] = bus.data_i;
    end else begin
      trig_n[7:0] = trig_r[7:0];
    end
    if (thi_wr_s) begin
      trig_n[15:8] = bus.data_i;
    end else begin
      trig_n[15:8] = trig_r[15:8];
    end
  end

  // Selected-channel view; an out-of-range select reads as zero
  always_comb begin
    sel_delay_s = 8'h00;
    sel_mode_s  = 8'h00;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_delay_s = (ch_sel_r == 3'(i)) ? 8'(delay_r[i]) : sel_delay_s;
      sel_mode_s  = (ch_sel_r == 3'(i)) ? {6'b000000, oneshot_r[i], pulse_r[i]} : sel_mode_s;
    end
  end

  // Read mux and read-data holding register
  always_comb begin
    rdata_s = 8'h00;
    case (bus.addr)
      REG_LINE:   rdata_s = 8'(lines_r);
      REG_ARM:    rdata_s = 8'(arm_r);
      REG_SEL:    rdata_s = {5'b00000, ch_sel_r};
      REG_DELAY:  rdata_s = sel_delay_s;
      REG_MODE:   rdata_s = sel_mode_s;
      REG_STATUS: rdata_s = 8'(pending_r);
      REG_TLO:    rdata_s = trig_r[7:0];
      REG_THI:    rdata_s = trig_r[15:8];
      default:    rdata_s = 8'h00;
    endcase
    if (rd_s) begin
      data_o_n = rdata_s;
    end else begin
      data_o_n = data_o_r;
    end
  end

  // State register with synchronous reset that aborts any countdown or pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      lines_r   <= '0;
      pending_r <= '0;
      arm_r     <= '0;
      pulse_r   <= '0;
      oneshot_r <= '0;
      ch_sel_r  <= 3'd0;
      trig_r    <= TRIG_RESET[15:0];
      data_o_r  <= 8'h00;
      for (int i = 0; i < NUM_CH; i++) begin
        delay_r[i] <= '0;
        cnt_r[i]   <= '0;
        pcnt_r[i]  <= '0;
      end
    end else begin
      lines_r   <= lines_n;
      pending_r <= pending_n;
      arm_r     <= arm_n;
      pulse_r   <= pulse_n;
      oneshot_r <= oneshot_n;
      ch_sel_r  <= ch_sel_n;
      trig_r    <= trig_n;
      data_o_r  <= data_o_n;
      for (int i = 0; i < NUM_CH; i++) begin
        delay_r[i] <= delay_n[i];
        cnt_r[i]   <= cnt_n[i];
        pcnt_r[i]  <= pcnt_n[i];
      end
    end
  end

endmodule
